dpram_param: RTL and testbench

Parametrised true dual-port synchronous RAM. It generalises the team's fixed 16x256 dual-port RAM with configurable width and depth, per-byte write enables, and a selectable read-during-write mode. It also adds an optional output pipeline stage, a power-on memory clear sequencer, and same-address collision detection and arbitration. It serves as the shared buffer between two independent clients in one clock domain.

---
 rtl/dpram_param.sv | 167 ++++++++++++++++
 tb/tb_dpram_param.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_param.sv
// Parametrised true dual-port RAM: byte enables, selectable read-during-write,
// optional output register, power-on clear sequencer and same-address collision tracking.
module dpram_param #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 8,
  parameter int OUT_REG        = 0,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  enb,
  input  logic [DATA_W/8-1:0]   wea,
  input  logic [DATA_W/8-1:0]   web,
  input  logic [ADDR_W-1:0]     addra,
  input  logic [ADDR_W-1:0]     addrb,
  input  logic [DATA_W-1:0]     data_i_a,
  input  logic [DATA_W-1:0]     data_i_b,
  output logic [DATA_W-1:0]     data_o_a,
  output logic [DATA_W-1:0]     data_o_b,
  output logic                  valid_o_a,
  output logic                  valid_o_b,
  output logic                  busy,
  output logic                  collision,
  output logic [15:0]           coll_cnt
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   clr_addr_q;
  logic                busy_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                act_a, act_b, wr_a, wr_b, coll;
  logic [DATA_W-1:0]   be_mask_a, be_mask_b;
  logic [DATA_W-1:0]   a_mask, b_mask, a_into_b, b_into_a, b_own;
  logic [DATA_W-1:0]   a_upd, b_upd, a_new, b_new;

  logic [DATA_W-1:0]   rd_a_q, rd_b_q;
  logic                vld_a_q, vld_b_q;
  logic                coll_q;
  logic [15:0]         coll_cnt_q, coll_cnt_d;

  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_mask
      assign be_mask_a[gi*8 +: 8] = {8{wea[gi]}};
      assign be_mask_b[gi*8 +: 8] = {8{web[gi]}};
    end
  endgenerate

  assign act_a = ena & ~busy_q;
  assign act_b = enb & ~busy_q;
  assign wr_a  = act_a & (|wea);
  assign wr_b  = act_b & (|web);
  assign coll  = act_a & act_b & (addra == addrb) & (wr_a | wr_b);

  // Byte ownership of the final word; on a shared address port A wins overlapping bytes.
  assign a_mask   = wr_a ? be_mask_a : '0;
  assign b_mask   = wr_b ? be_mask_b : '0;
  assign a_into_b = coll ? a_mask : '0;
  assign b_into_a = coll ? (b_mask & ~a_mask) : '0;
  assign b_own    = b_mask & ~a_into_b;

  assign a_upd = a_mask | b_into_a;
  assign a_new = (data_i_a & a_mask) | (data_i_b & b_into_a);
  assign b_upd = b_own | a_into_b;
  assign b_new = (data_i_b & b_own) | (data_i_a & a_into_b);

  assign coll_cnt_d = (coll && coll_cnt_q != 16'hFFFF) ? coll_cnt_q + 16'd1 : coll_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      busy_q     <= (CLEAR_ON_RESET != 0);
      clr_addr_q <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == '1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Array storage carries no reset; the clear sequencer zero-fills it instead.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_addr_q] <= '0;
    end else begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_b && web[i]) mem[addrb][i*8 +: 8] <= data_i_b[i*8 +: 8];
        if (wr_a && wea[i]) mem[addra][i*8 +: 8] <= data_i_a[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      vld_a_q    <= 1'b0;
      vld_b_q    <= 1'b0;
      coll_q     <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      vld_a_q    <= act_a;
      vld_b_q    <= act_b;
      coll_q     <= coll;
      coll_cnt_q <= coll_cnt_d;
      if (act_a) begin
        rd_a_q <= (RDW_MODE != 0 && wr_a) ? ((mem[addra] & ~a_upd) | a_new) : mem[addra];
      end
      if (act_b) begin
        rd_b_q <= (RDW_MODE != 0 && wr_b) ? ((mem[addrb] & ~b_upd) | b_new) : mem[addrb];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] out_a_q, out_b_q;
      logic              ov_a_q, ov_b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_a_q <= '0;
          out_b_q <= '0;
          ov_a_q  <= 1'b0;
          ov_b_q  <= 1'b0;
        end else begin
          ov_a_q <= vld_a_q;
          ov_b_q <= vld_b_q;
          if (vld_a_q) out_a_q <= rd_a_q;
          if (vld_b_q) out_b_q <= rd_b_q;
        end
      end

      assign data_o_a  = out_a_q;
      assign data_o_b  = out_b_q;
      assign valid_o_a = ov_a_q;
      assign valid_o_b = ov_b_q;
    end else begin : g_noreg
      assign data_o_a  = rd_a_q;
      assign data_o_b  = rd_b_q;
      assign valid_o_a = vld_a_q;
      assign valid_o_b = vld_b_q;
    end
  endgenerate

  assign busy      = busy_q;
  assign collision = coll_q;
  assign coll_cnt  = coll_cnt_q;

endmodule

// File: tb/tb_dpram_param.sv
// Bench for dpram_param: two instances (latency 1 read-first, latency 2 write-first)
// share stimulus and are compared against a word-level reference model.
module tb_dpram_param;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ena = 1'b0, enb = 1'b0;
  logic [BW-1:0] wea = '0, web = '0;
  logic [AW-1:0] addra = '0, addrb = '0;
  logic [DW-1:0] dia = '0, dib = '0;

  logic [DW-1:0] da0, db0, da1, db1;
  logic va0, vb0, va1, vb1, busy0, busy1, coll0, coll1;
  logic [15:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpram_param #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .data_i_a(dia), .data_i_b(dib),
    .data_o_a(da0), .data_o_b(db0), .valid_o_a(va0), .valid_o_b(vb0),
    .busy(busy0), .collision(coll0), .coll_cnt(cnt0));

  dpram_param #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .data_i_a(dia), .data_i_b(dib),
    .data_o_a(da1), .data_o_b(db1), .valid_o_a(va1), .valid_o_b(vb1),
    .busy(busy1), .collision(coll1), .coll_cnt(cnt1));

  // Reference model state
  logic [DW-1:0] mmem [DEPTH];
  int            busy_left;
  logic          m_coll;
  logic [15:0]   m_cnt;
  logic [DW-1:0] e0a, e0b, e1a, e1b, p1a, p1b;
  logic          v0a, v0b, v1a, v1b, pv1a, pv1b;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < BW; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [103:0] exp_all();
    logic bz;
    bz = (busy_left > 0);
    return {bz, m_coll, m_cnt, v0a, v0b, e0a, e0b,
            bz, m_coll, m_cnt, v1a, v1b, e1a, e1b};
  endfunction

  function automatic logic [103:0] obs_all();
    return {busy0, coll0, cnt0, va0, vb0, da0, db0,
            busy1, coll1, cnt1, va1, vb1, da1, db1};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    busy_left = DEPTH;
    m_coll = 1'b0; m_cnt = '0;
    e0a = '0; e0b = '0; e1a = '0; e1b = '0; p1a = '0; p1b = '0;
    v0a = 1'b0; v0b = 1'b0; v1a = 1'b0; v1b = 1'b0; pv1a = 1'b0; pv1b = 1'b0;
  endtask

  task automatic idle_inputs();
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
  endtask

  // Apply the access rules for the coming edge to the model, then advance the DUTs.
  task automatic step();
    logic bn, aa, ab, wa, wb, cl;
    logic [DW-1:0] oa, ob, fa, fb, w;
    bn = (busy_left > 0);
    aa = ena && !bn;
    ab = enb && !bn;
    wa = aa && (wea != '0);
    wb = ab && (web != '0);
    cl = aa && ab && (addra == addrb) && (wa || wb);
    oa = mmem[addra];
    ob = mmem[addrb];
    if (cl) begin
      w = merge(ob, dib, web);
      w = merge(w, dia, wea);
      mmem[addra] = w;
      fa = w; fb = w;
    end else begin
      fa = merge(oa, dia, wa ? wea : '0);
      fb = merge(ob, dib, wb ? web : '0);
      if (wa) mmem[addra] = fa;
      if (wb) mmem[addrb] = fb;
    end
    if (bn) busy_left--;
    m_coll = cl;
    if (cl && m_cnt != 16'hFFFF) m_cnt++;
    v0a = aa; v0b = ab;
    if (aa) e0a = oa;
    if (ab) e0b = ob;
    v1a = pv1a; v1b = pv1b;
    if (pv1a) e1a = p1a;
    if (pv1b) e1b = p1b;
    pv1a = aa; pv1b = ab;
    if (aa) p1a = wa ? fa : oa;
    if (ab) p1b = wb ? fb : ob;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (obs_all() !== exp_all()) begin
      errors++; $display("FAIL reset_state got %h exp %h", obs_all(), exp_all());
    end
    for (int i = 0; i < DEPTH; i++) begin
      ena = 1'b1; wea = '1; addra = AW'(i); dia = DW'($urandom);
      step();
      checks++;
      if (obs_all() !== exp_all()) begin
        errors++; $display("FAIL clear_cycle %0d got %h exp %h", i, obs_all(), exp_all());
      end
      checks++;
      if (busy0 !== (i < DEPTH - 1)) begin
        errors++; $display("FAIL busy_len cycle %0d got %b exp %b", i, busy0, (i < DEPTH - 1));
      end
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      idle_inputs();
      if (i < DEPTH) begin ena = 1'b1; addra = AW'(i); end
      step();
      checks++;
      if (obs_all() !== exp_all() || (i < DEPTH && da0 !== '0)) begin
        errors++; $display("FAIL cleared_read %0d got %h exp %h", i, obs_all(), exp_all());
      end
    end
  endtask

  task automatic test_byte_enable();
    logic [DW-1:0] wd [3];
    logic [BW-1:0] wb [3];
    wd[0] = 16'hABCD; wd[1] = 16'h1234; wd[2] = 16'h0000;
    wb[0] = 2'b11;    wb[1] = 2'b01;    wb[2] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      if (i < 3) begin ena = 1'b1; addra = 4'd3; wea = wb[i]; dia = wd[i]; end
      step();
      checks++;
      if (obs_all() !== exp_all()) begin
        errors++; $display("FAIL byte_en step %0d got %h exp %h", i, obs_all(), exp_all());
      end
    end
    checks++;
    if (da0 !== 16'hAB34 || da1 !== 16'hAB34) begin
      errors++; $display("FAIL byte_en_value got %h/%h exp ab34", da0, da1);
    end
  endtask

  task automatic test_rdw();
    idle_inputs(); ena = 1'b1; addra = 4'd7; wea = 2'b11; dia = 16'h0001;
    step();
    dia = 16'h00FF;
    step();
    checks++;
    if (obs_all() !== exp_all() || da0 !== 16'h0001) begin
      errors++; $display("FAIL rdw_read_first got %h exp %h", da0, 16'h0001);
    end
    idle_inputs();
    step();
    checks++;
    if (obs_all() !== exp_all() || da1 !== 16'h00FF) begin
      errors++; $display("FAIL rdw_write_first got %h exp %h", da1, 16'h00FF);
    end
  endtask

  task automatic test_collision();
    idle_inputs();
    ena = 1'b1; enb = 1'b1; addra = 4'd9; addrb = 4'd9;
    wea = 2'b10; dia = 16'hAAAA; web = 2'b11; dib = 16'h5555;
    step();
    checks++;
    if (obs_all() !== exp_all() || coll0 !== 1'b1 || cnt0 !== 16'd1) begin
      errors++; $display("FAIL coll_pulse got coll=%b cnt=%0d exp coll=1 cnt=1", coll0, cnt0);
    end
    idle_inputs(); ena = 1'b1; addra = 4'd9;
    step();
    checks++;
    if (obs_all() !== exp_all() || coll0 !== 1'b0 || cnt1 !== 16'd1 || da1 !== 16'hAA55) begin
      errors++; $display("FAIL coll_after got coll=%b cnt=%0d d1=%h exp 0 1 aa55", coll0, cnt1, da1);
    end
    checks++;
    if (da0 !== 16'hAA55) begin
      errors++; $display("FAIL coll_stored got %h exp aa55", da0);
    end
  endtask

  task automatic test_latency();
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); ena = 1'b1; wea = '1; addra = AW'(i); dia = DW'(16'h1111 * (i + 1));
      step();
    end
    idle_inputs();
    step();
    for (int k = 0; k < 6; k++) begin
      logic          ev;
      logic [DW-1:0] ed;
      idle_inputs();
      if (k < 3) begin enb = 1'b1; addrb = AW'(k); end
      step();
      ev = (k >= 1 && k <= 3);
      ed = DW'(16'h1111 * ((k < 1) ? 3 : (k > 3 ? 3 : k)));
      checks++;
      if (obs_all() !== exp_all() || vb1 !== ev || (ev && db1 !== ed)) begin
        errors++; $display("FAIL latency edge %0d got v=%b d=%h exp v=%b d=%h", k, vb1, db1, ev, ed);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      ena = 1'($urandom); enb = 1'($urandom);
      addra = AW'($urandom_range(0, 3)); addrb = AW'($urandom_range(0, 3));
      wea = BW'($urandom); web = BW'($urandom);
      dia = DW'($urandom); dib = DW'($urandom);
      step();
      checks++;
      if (obs_all() !== exp_all()) begin
        errors++; $display("FAIL random cycle %0d got %h exp %h", n, obs_all(), exp_all());
      end
    end
  endtask

  task automatic test_mid_clear();
    idle_inputs();
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs_all() !== exp_all()) begin
      errors++; $display("FAIL async_reset got %h exp %h", obs_all(), exp_all());
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      ena = 1'b1; wea = '1; addra = AW'(i); dia = 16'hFFFF;
      step();
      checks++;
      if (obs_all() !== exp_all() || busy0 !== (i < DEPTH - 1) || cnt0 !== 16'd0) begin
        errors++; $display("FAIL mid_clear cycle %0d busy=%b cnt=%0d got %h exp %h",
                           i, busy0, cnt0, obs_all(), exp_all());
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte_enable();
    test_rdw();
    test_collision();
    test_latency();
    test_random();
    test_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
